// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and the coordinate type used by the
// sync generator, the icon overlay and the colorizer.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_span(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate enable divider: one-clock pix_en strobe every CLK_DIV system clocks
// while run is high.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic pix_en
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pix_tick_gen: CLK_DIV must be in 1..16");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt;
  logic [3:0] div_nxt;

  always_comb begin
    div_nxt = div_cnt + 4'd1;
    if (div_cnt == DIV_LAST) div_nxt = '0;
  end

  // pix_en is registered from the next count so it is high exactly while
  // div_cnt sits at CLK_DIV-1; with CLK_DIV=1 that is every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (run) begin
      div_cnt <= div_nxt;
      pix_en  <= (div_nxt == DIV_LAST);
    end else begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-enable divider, h/v counters,
// registered sync/blanking/coordinate outputs and per-frame strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT        = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT        = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [1:0] rst_sync;
  logic       run;
  logic       active;
  logic       cnt_moved;
  coord_t     h_cnt;
  coord_t     v_cnt;
  logic [7:0] frame_cnt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       video_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .pix_en (pix_en)
  );

  // The first pixel strobe after reset only arms the outputs so that (0,0)
  // is shown for a full pixel period before the counters start moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt_moved <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      cnt_moved <= 1'b0;
      if (pix_en) begin
        if (!active) begin
          active <= 1'b1;
        end else begin
          cnt_moved <= 1'b1;
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt     <= '0;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              v_cnt <= v_cnt + 10'd1;
            end
          end else begin
            h_cnt <= h_cnt + 10'd1;
          end
        end
      end
    end
  end

  always_comb begin
    hsync_nxt = !in_span(h_cnt, H_SYNC_START, H_SYNC_END);
    vsync_nxt = !in_span(v_cnt, V_SYNC_START, V_SYNC_END);
    video_nxt = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

  // Strobes key off cnt_moved so they fire once per arrival, not once per clk
  // the counters dwell on the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      horiz_sync   <= 1'b1;
      vert_sync    <= 1'b1;
      video_on     <= 1'b0;
      pixel_column <= '0;
      pixel_row    <= '0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else if (active) begin
      horiz_sync   <= hsync_nxt;
      vert_sync    <= vsync_nxt;
      video_on     <= video_nxt;
      pixel_column <= h_cnt;
      pixel_row    <= v_cnt;
      frame_start  <= cnt_moved && (h_cnt == '0) && (v_cnt == '0);
      vblank_start <= cnt_moved && (h_cnt == '0) && (v_cnt == V_ACT);
      frame_count  <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen: full-size instance for reset
// and line timing, reduced-geometry instances for frame, wrap and CLK_DIV=1.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic       a_pix_en, a_hs, a_vs, a_von, a_fs, a_vb;
  logic [9:0] a_col, a_row;
  logic [7:0] a_fc;
  logic       b_pix_en, b_hs, b_vs, b_von, b_fs, b_vb;
  logic [9:0] b_col, b_row;
  logic [7:0] b_fc;
  logic       c_pix_en, c_hs, c_vs, c_von, c_fs, c_vb;
  logic [9:0] c_col, c_row;
  logic [7:0] c_fc;

  localparam logic [33:0] RST_VEC = {6'b011000, 28'd0};

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(a_pix_en), .horiz_sync(a_hs), .vert_sync(a_vs),
    .video_on(a_von), .pixel_column(a_col), .pixel_row(a_row), .frame_start(a_fs),
    .vblank_start(a_vb), .frame_count(a_fc)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(b_pix_en), .horiz_sync(b_hs), .vert_sync(b_vs),
    .video_on(b_von), .pixel_column(b_col), .pixel_row(b_row), .frame_start(b_fs),
    .vblank_start(b_vb), .frame_count(b_fc)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .pix_en(c_pix_en), .horiz_sync(c_hs), .vert_sync(c_vs),
    .video_on(c_von), .pixel_column(c_col), .pixel_row(c_row), .frame_start(c_fs),
    .vblank_start(c_vb), .frame_count(c_fc)
  );

  function automatic logic [33:0] a_vec();
    return {a_pix_en, a_hs, a_vs, a_von, a_fs, a_vb, a_col, a_row, a_fc};
  endfunction

  function automatic logic [33:0] b_vec();
    return {b_pix_en, b_hs, b_vs, b_von, b_fs, b_vb, b_col, b_row, b_fc};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    int m;
    logic changed;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (a_vec() !== RST_VEC) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", a_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    n = 0;
    changed = 1'b0;
    while (!a_pix_en && n < 20) begin
      @(negedge clk);
      n++;
      if (!a_pix_en && a_vec() !== RST_VEC) changed = 1'b1;
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL first_pix_en: got cycle %0d want 5", n);
    end
    total++;
    if (changed !== 1'b0) begin
      bad++;
      $display("FAIL hold_before_pix_en: got changed=%0b want 0", changed);
    end
    @(negedge clk);
    m = 1;
    while (!a_pix_en && m < 20) begin
      @(negedge clk);
      m++;
    end
    total++;
    if (m != 4) begin
      bad++;
      $display("FAIL pix_en_period: got %0d want 4", m);
    end
    total++;
    if ({a_von, a_hs, a_vs, a_col, a_row} !== {3'b111, 20'd0}) begin
      bad++;
      $display("FAIL first_pixel: got von=%0b hs=%0b vs=%0b col=%0d row=%0d want 1 1 1 0 0",
               a_von, a_hs, a_vs, a_col, a_row);
    end
  endtask

  task automatic test_line();
    int n;
    int cnt;
    int hs_low;
    int fall;
    int rise;
    int von_err;
    logic prev_hs;
    n = 0;
    while (a_row != 10'd1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    cnt = 0; hs_low = 0; fall = -1; rise = -1; von_err = 0; prev_hs = 1'b1;
    do begin
      if (a_row == 10'd1) begin
        if (!a_hs) hs_low++;
        if (prev_hs && !a_hs) fall = int'(a_col);
        if (!prev_hs && a_hs) rise = int'(a_col);
        prev_hs = a_hs;
        if (a_von !== (a_col < 10'd640)) von_err++;
      end
      @(negedge clk);
      cnt++;
    end while (a_row != 10'd2 && cnt < 4000);
    total++;
    if (cnt != 3200) begin bad++; $display("FAIL line_period: got %0d want 3200", cnt); end
    total++;
    if (hs_low != 384) begin bad++; $display("FAIL hsync_low_clk: got %0d want 384", hs_low); end
    total++;
    if (fall != 656) begin bad++; $display("FAIL hsync_fall_col: got %0d want 656", fall); end
    total++;
    if (rise != 752) begin bad++; $display("FAIL hsync_rise_col: got %0d want 752", rise); end
    total++;
    if (von_err != 0) begin bad++; $display("FAIL video_on_line: got %0d errors want 0", von_err); end
  endtask

  task automatic test_frame();
    int n;
    int cnt;
    int vs_low;
    int vs_row_err;
    int vb_cnt;
    int vb_pos_err;
    int von_err;
    do_reset();
    n = 0;
    while (!b_fs && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 133) begin bad++; $display("FAIL first_frame_start: got cycle %0d want 133", n); end
    total++;
    if ({b_col, b_row, b_fc} !== {10'd0, 10'd0, 8'd1}) begin
      bad++;
      $display("FAIL frame_start_pos: got col=%0d row=%0d fc=%0d want 0 0 1", b_col, b_row, b_fc);
    end
    cnt = 0; vs_low = 0; vs_row_err = 0; vb_cnt = 0; vb_pos_err = 0; von_err = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (!b_vs) begin
        vs_low++;
        if (b_row != 10'd5 && b_row != 10'd6) vs_row_err++;
      end
      if (b_vb) begin
        vb_cnt++;
        if (b_col != 10'd0 || b_row != 10'd4) vb_pos_err++;
      end
      if (b_von !== ((b_col < 10'd4) && (b_row < 10'd4))) von_err++;
    end while (!b_fs && cnt < 400);
    total++;
    if (cnt != 128) begin bad++; $display("FAIL frame_period: got %0d want 128", cnt); end
    total++;
    if (vs_low != 32) begin bad++; $display("FAIL vsync_low_clk: got %0d want 32", vs_low); end
    total++;
    if (vs_row_err != 0) begin bad++; $display("FAIL vsync_rows: got %0d errors want 0", vs_row_err); end
    total++;
    if (vb_cnt != 1) begin bad++; $display("FAIL vblank_count: got %0d want 1", vb_cnt); end
    total++;
    if (vb_pos_err != 0) begin bad++; $display("FAIL vblank_pos: got %0d errors want 0", vb_pos_err); end
    total++;
    if (von_err != 0) begin bad++; $display("FAIL video_on_frame: got %0d errors want 0", von_err); end
    total++;
    if (b_fc !== 8'd2) begin bad++; $display("FAIL frame_count_step: got %0d want 2", b_fc); end
  endtask

  task automatic test_wrap();
    int cnt;
    int fc_err;
    int per_err;
    int wrap_seen;
    logic [7:0] exp_fc;
    exp_fc = 8'd2; fc_err = 0; per_err = 0; wrap_seen = 0;
    for (int f = 0; f < 256; f++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!b_fs && cnt < 400);
      exp_fc = exp_fc + 8'd1;
      if (b_fc !== exp_fc) fc_err++;
      if (cnt != 128) per_err++;
      if (exp_fc == 8'd0 && b_fc == 8'd0) wrap_seen++;
    end
    total++;
    if (fc_err != 0) begin bad++; $display("FAIL frame_count_seq: got %0d errors want 0", fc_err); end
    total++;
    if (per_err != 0) begin bad++; $display("FAIL frame_period_all: got %0d errors want 0", per_err); end
    total++;
    if (wrap_seen != 1) begin bad++; $display("FAIL frame_count_wrap: got %0d want 1", wrap_seen); end
  endtask

  task automatic test_midframe_reset();
    int n;
    n = 0;
    while (!(b_col == 10'd3 && b_row == 10'd2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (b_vec() !== RST_VEC) begin
      bad++;
      $display("FAIL async_reset_b: got %b want %b", b_vec(), RST_VEC);
    end
    total++;
    if (a_vec() !== RST_VEC) begin
      bad++;
      $display("FAIL async_reset_a: got %b want %b", a_vec(), RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!b_von && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL restart_cycle: got %0d want 5", n); end
    total++;
    if ({b_col, b_row, b_fc} !== 28'd0) begin
      bad++;
      $display("FAIL restart_pos: got col=%0d row=%0d fc=%0d want 0 0 0", b_col, b_row, b_fc);
    end
  endtask

  task automatic test_clkdiv1();
    int n;
    int cnt;
    int hs_low;
    int fall;
    int rise;
    int pe_err;
    logic prev_hs;
    do_reset();
    n = 0;
    while (!c_pix_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL div1_first_pix_en: got %0d want 3", n); end
    pe_err = 0;
    n = 0;
    while (c_row != 10'd1 && n < 100) begin
      @(negedge clk);
      n++;
      if (!c_pix_en) pe_err++;
    end
    cnt = 0; hs_low = 0; fall = -1; rise = -1; prev_hs = 1'b1;
    do begin
      if (c_row == 10'd1) begin
        if (!c_hs) hs_low++;
        if (prev_hs && !c_hs) fall = int'(c_col);
        if (!prev_hs && c_hs) rise = int'(c_col);
        prev_hs = c_hs;
      end
      @(negedge clk);
      cnt++;
      if (!c_pix_en) pe_err++;
    end while (c_row != 10'd2 && cnt < 100);
    total++;
    if (pe_err != 0) begin bad++; $display("FAIL div1_pix_en_const: got %0d low samples want 0", pe_err); end
    total++;
    if (cnt != 8) begin bad++; $display("FAIL div1_line_period: got %0d want 8", cnt); end
    total++;
    if (hs_low != 2) begin bad++; $display("FAIL div1_hsync_low: got %0d want 2", hs_low); end
    total++;
    if (fall != 5 || rise != 7) begin
      bad++;
      $display("FAIL div1_hsync_edges: got fall=%0d rise=%0d want 5 7", fall, rise);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_midframe_reset();
    test_clkdiv1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
